i2s_sample_feeder: RTL and testbench

I2S_SAMPLE_FEEDER -- requirements
Module: i2s_sample_feeder

---
 rtl/i2s_sample_feeder_pkg.sv | 17 +
 rtl/i2s_sample_feeder_if.sv | 46 ++++
 rtl/sample_fifo.sv | 78 +++++++
 rtl/i2s_sample_feeder.sv | 154 +++++++++++++++
 tb/tb_i2s_sample_feeder.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_sample_feeder_pkg.sv
// Shared constants and state encoding for the I2S sample feeder.
// Defaults here are picked up by the interface, the FIFO and the top module.
package i2s_sample_feeder_pkg;

    localparam int BPS_DEFAULT         = 24;
    localparam int DEPTH_DEFAULT       = 16;
    localparam int START_LEVEL_DEFAULT = 8;
    localparam int HOLD_CYCLES_DEFAULT = 6;

    localparam logic [7:0] UNDERRUN_MAX = 8'hFF;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/i2s_sample_feeder_if.sv
// Producer write channel and I2S transmitter channel of the sample feeder.
// The slave modport is the feeder's view; master is the surrounding system.
interface i2s_sample_feeder_if
    import i2s_sample_feeder_pkg::*;
#(
    parameter int BPS   = BPS_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic [BPS-1:0] in_wr_data;
    logic           in_wr_valid;
    logic           out_wr_ready;
    logic [BPS-1:0] out_sample;
    logic           out_en;
    logic           in_ready;
    logic [LW-1:0]  out_level;
    logic           out_streaming;
    logic [7:0]     out_underrun_cnt;

    modport slave (
        input  in_wr_data,
        input  in_wr_valid,
        input  in_ready,
        output out_wr_ready,
        output out_sample,
        output out_en,
        output out_level,
        output out_streaming,
        output out_underrun_cnt
    );

    modport master (
        output in_wr_data,
        output in_wr_valid,
        output in_ready,
        input  out_wr_ready,
        input  out_sample,
        input  out_en,
        input  out_level,
        input  out_streaming,
        input  out_underrun_cnt
    );

endinterface

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO: write handshake, pop strobe, head data and level.
// DEPTH is a power of two so the pointers wrap by natural overflow.
module sample_fifo
    import i2s_sample_feeder_pkg::*;
#(
    parameter int WIDTH = BPS_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       wr_ready,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          wr_en;
    logic          rd_en;

    // Readiness depends only on the stored level, never on a same-cycle pop.
    always_comb begin
        wr_ready = (level_q < FULL_LEVEL);
        empty    = (level_q == '0);
        wr_en    = wr_valid && wr_ready;
        rd_en    = pop && !empty;
        head     = mem_q[rd_ptr_q];

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/i2s_sample_feeder.sv
// Feeds buffered samples to an I2S transmitter: output register, post-handshake
// hold timer, FILL/STREAM pre-roll state machine and a saturating underrun counter.
module i2s_sample_feeder
    import i2s_sample_feeder_pkg::*;
#(
    parameter int BPS         = BPS_DEFAULT,
    parameter int DEPTH       = DEPTH_DEFAULT,
    parameter int START_LEVEL = START_LEVEL_DEFAULT,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
    input  logic                in_clk,
    input  logic                in_rst_n,
    i2s_sample_feeder_if.slave  bus
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int HW = $clog2(HOLD_CYCLES + 2);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(1);
    localparam logic [LW:0]   START_CMP = (LW+1)'(START_LEVEL);

    feeder_state_t  state_q, state_d;
    logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [BPS-1:0] sample_q, sample_d;
    logic           out_valid_q, out_valid_d;
    logic           ready_q, ready_d;
    logic           was_stream_q, was_stream_d;
    logic [7:0]     underrun_q, underrun_d;

    logic           fifo_pop;
    logic [BPS-1:0] fifo_head;
    logic [LW-1:0]  fifo_level;
    logic           fifo_wr_ready;
    logic           fifo_empty;

    logic           hold_pending;
    logic           out_en_w;
    logic           handshake;
    logic           refill;
    logic           ready_rise;
    logic           underrun_evt;
    logic [LW:0]    fill_count;

    sample_fifo #(
        .WIDTH (BPS),
        .DEPTH (DEPTH)
    ) u_sample_fifo (
        .clk      (in_clk),
        .rst_n    (in_rst_n),
        .wr_valid (bus.in_wr_valid),
        .wr_data  (bus.in_wr_data),
        .wr_ready (fifo_wr_ready),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .level    (fifo_level),
        .empty    (fifo_empty)
    );

    // Output register and hold timer: the presented sample is frozen for the
    // whole hold window and only refilled from the FIFO head when it expires.
    always_comb begin
        hold_pending = (hold_cnt_q != '0);
        out_en_w     = (state_q == STREAM) && out_valid_q && !hold_pending;
        handshake    = bus.in_ready && out_en_w;

        hold_cnt_d  = hold_cnt_q;
        sample_d    = sample_q;
        out_valid_d = out_valid_q;
        fifo_pop    = 1'b0;
        refill      = 1'b0;

        if (handshake) begin
            hold_cnt_d = HOLD_LOAD;
            refill     = (HOLD_CYCLES == 0);
        end else if (hold_pending) begin
            hold_cnt_d = hold_cnt_q - 1'b1;
            refill     = (hold_cnt_q == HOLD_LAST);
        end else if (!out_valid_q) begin
            refill = 1'b1;
        end

        if (refill) begin
            if (!fifo_empty) begin
                fifo_pop    = 1'b1;
                sample_d    = fifo_head;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Pre-roll counts the sample already sitting in the output register.
    always_comb begin
        fill_count = {1'b0, fifo_level} + {{LW{1'b0}}, out_valid_q};
        state_d    = state_q;

        case (state_q)
            FILL: begin
                if (fill_count >= START_CMP) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if ((fifo_level == '0) && !out_valid_q && !hold_pending) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // A request edge that finds nothing to hand over counts as an underrun,
    // including the cycle right after falling back to FILL.
    always_comb begin
        ready_rise   = bus.in_ready && !ready_q;
        underrun_evt = ready_rise && !out_en_w && ((state_q == STREAM) || was_stream_q);
        ready_d      = bus.in_ready;
        was_stream_d = (state_q == STREAM);
        underrun_d   = underrun_q;

        if (underrun_evt && (underrun_q != UNDERRUN_MAX)) begin
            underrun_d = underrun_q + 8'd1;
        end
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_q      <= FILL;
            hold_cnt_q   <= '0;
            sample_q     <= '0;
            out_valid_q  <= 1'b0;
            ready_q      <= 1'b0;
            was_stream_q <= 1'b0;
            underrun_q   <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            sample_q     <= sample_d;
            out_valid_q  <= out_valid_d;
            ready_q      <= ready_d;
            was_stream_q <= was_stream_d;
            underrun_q   <= underrun_d;
        end
    end

    assign bus.out_wr_ready     = fifo_wr_ready;
    assign bus.out_sample       = sample_q;
    assign bus.out_en           = out_en_w;
    assign bus.out_level        = fifo_level;
    assign bus.out_streaming    = (state_q == STREAM);
    assign bus.out_underrun_cnt = underrun_q;

endmodule

// File: tb/tb_i2s_sample_feeder.sv
// Directed bench for i2s_sample_feeder; a scoreboard queue holds every accepted
// write and a monitor checks each consumed sample against it in order.
`timescale 1ns/1ps
module tb_i2s_sample_feeder;

    localparam int BPS   = 24;
    localparam int DEPTH = 16;
    localparam int HOLD  = 6;

    logic in_clk = 1'b0;
    logic in_rst_n = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    logic [BPS-1:0] sb_q [$];
    logic [BPS-1:0] sb_exp;

    i2s_sample_feeder_if #(.BPS(BPS), .DEPTH(DEPTH)) bus ();

    i2s_sample_feeder #(
        .BPS         (BPS),
        .DEPTH       (DEPTH),
        .START_LEVEL (8),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .in_clk   (in_clk),
        .in_rst_n (in_rst_n),
        .bus      (bus)
    );

    always #5 in_clk = ~in_clk;

    task automatic cycle();
        @(posedge in_clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic write_sample(input logic [BPS-1:0] data);
        bus.in_wr_data  = data;
        bus.in_wr_valid = 1'b1;
        cycle();
        bus.in_wr_valid = 1'b0;
    endtask

    task automatic wait_out_en(input int budget, input string name);
        int n = 0;
        while (!bus.out_en && n < budget) begin
            cycle();
            n++;
        end
        check_output(name, 32'(bus.out_en), 1);
    endtask

    task automatic pulse_ready();
        bus.in_ready = 1'b1;
        cycle();
        bus.in_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_sample"},   32'(bus.out_sample), 0);
        check_output({tag, "_en"},       32'(bus.out_en), 0);
        check_output({tag, "_level"},    32'(bus.out_level), 0);
        check_output({tag, "_wr_ready"}, 32'(bus.out_wr_ready), 1);
        check_output({tag, "_stream"},   32'(bus.out_streaming), 0);
        check_output({tag, "_underrun"}, 32'(bus.out_underrun_cnt), 0);
    endtask

    // Monitor: a reset edge discards everything; otherwise every handshake pops
    // the oldest expected sample and every accepted write pushes a new one.
    initial begin
        forever begin
            @(negedge in_clk);
            if (!in_rst_n) begin
                sb_q.delete();
            end else begin
                if (bus.in_ready && bus.out_en) begin
                    tests_run++;
                    if (sb_q.size() == 0) begin
                        tests_failed++;
                        $display("[TB] FAIL sb_pop: consumed 0x%0h with no expected sample", bus.out_sample);
                    end else begin
                        sb_exp = sb_q.pop_front();
                        if (bus.out_sample !== sb_exp) begin
                            tests_failed++;
                            $display("[TB] FAIL sb_sample: got 0x%0h expected 0x%0h", bus.out_sample, sb_exp);
                        end
                    end
                end
                if (bus.in_wr_valid && bus.out_wr_ready) begin
                    sb_q.push_back(bus.in_wr_data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int hs;
        int last;

        bus.in_wr_data  = '0;
        bus.in_wr_valid = 1'b0;
        bus.in_ready    = 1'b0;
        in_rst_n        = 1'b0;
        repeat (3) @(posedge in_clk);
        #1;
        check_reset_values("reset");
        in_rst_n = 1'b1;
        cycle();

        // Pre-roll: seven samples are not enough to start streaming.
        for (int i = 1; i <= 7; i++) begin
            write_sample(24'h100000 + 24'(i));
        end
        cycle();
        cycle();
        check_output("fill_en", 32'(bus.out_en), 0);
        check_output("fill_stream", 32'(bus.out_streaming), 0);
        check_output("fill_level", 32'(bus.out_level), 6);
        check_output("fill_sample", 32'(bus.out_sample), 32'h100001);

        write_sample(24'hA5A5A5);
        n = 0;
        while (!(bus.out_streaming && bus.out_en) && n < 2) begin
            cycle();
            n++;
        end
        check_output("start_stream", 32'(bus.out_streaming), 1);
        check_output("start_en", 32'(bus.out_en), 1);
        check_output("start_sample", 32'(bus.out_sample), 32'h100001);
        check_output("start_level", 32'(bus.out_level), 7);

        // Single handshake: six frozen cycles, then the next sample.
        pulse_ready();
        for (int k = 1; k <= HOLD; k++) begin
            check_output($sformatf("hold_en_%0d", k), 32'(bus.out_en), 0);
            check_output($sformatf("hold_sample_%0d", k), 32'(bus.out_sample), 32'h100001);
            cycle();
        end
        check_output("after_hold_en", 32'(bus.out_en), 1);
        check_output("after_hold_sample", 32'(bus.out_sample), 32'h100002);
        check_output("after_hold_level", 32'(bus.out_level), 6);
        check_output("no_underrun_1", 32'(bus.out_underrun_cnt), 0);

        // Fill the memory completely, then offer one more sample.
        for (int i = 1; i <= 10; i++) begin
            write_sample(24'h200000 + 24'(i));
        end
        check_output("full_level", 32'(bus.out_level), 16);
        check_output("full_wr_ready", 32'(bus.out_wr_ready), 0);
        write_sample(24'hDEAD01);
        check_output("refused_level", 32'(bus.out_level), 16);
        check_output("refused_wr_ready", 32'(bus.out_wr_ready), 0);

        // Continuous request: one consumption every HOLD+1 cycles.
        bus.in_ready = 1'b1;
        hs = 0;
        last = -1;
        for (int c = 0; c < 35; c++) begin
            if (bus.out_en) begin
                if (last >= 0) begin
                    check_output("hs_gap", 32'(c - last), HOLD + 1);
                end
                last = c;
                hs++;
            end
            cycle();
        end
        check_output("hs_count", 32'(hs), 5);
        check_output("no_underrun_2", 32'(bus.out_underrun_cnt), 0);

        // Drain to empty, then request once more with nothing to give.
        n = 0;
        while (!(bus.out_en && bus.out_level == 0) && n < 200) begin
            cycle();
            n++;
        end
        check_output("drain_last", 32'(bus.out_en && bus.out_level == 0), 1);
        cycle();
        bus.in_ready = 1'b0;
        n = 0;
        while (bus.out_streaming && n < 20) begin
            cycle();
            n++;
        end
        check_output("drain_exit", 32'(bus.out_streaming), 0);
        pulse_ready();
        check_output("underrun_one", 32'(bus.out_underrun_cnt), 1);
        check_output("underrun_state", 32'(bus.out_streaming), 0);
        check_output("underrun_en", 32'(bus.out_en), 0);
        check_output("sb_drained", 32'(sb_q.size()), 0);

        // Many request edges while streaming must saturate the counter.
        for (int i = 1; i <= 16; i++) begin
            write_sample(24'h300000 + 24'(i));
        end
        check_output("restream", 32'(bus.out_streaming), 1);
        for (int c = 0; c < 1000; c++) begin
            bus.in_ready    = (c % 2) == 1;
            bus.in_wr_valid = 1'b1;
            bus.in_wr_data  = 24'h400000 + 24'(c);
            cycle();
        end
        bus.in_ready    = 1'b0;
        bus.in_wr_valid = 1'b0;
        cycle();
        check_output("underrun_sat", 32'(bus.out_underrun_cnt), 255);
        check_output("sat_stream", 32'(bus.out_streaming), 1);

        // Reset mid-stream discards everything stored.
        in_rst_n = 1'b0;
        cycle();
        in_rst_n = 1'b1;
        check_reset_values("midreset");
        for (int i = 1; i <= 8; i++) begin
            write_sample(24'hC00000 + 24'(i));
        end
        wait_out_en(4, "post_reset_en");
        check_output("post_reset_sample", 32'(bus.out_sample), 32'hC00001);
        for (int i = 0; i < 3; i++) begin
            wait_out_en(10, "post_reset_hs_en");
            pulse_ready();
        end
        wait_out_en(10, "post_reset_final_en");
        check_output("post_reset_fourth", 32'(bus.out_sample), 32'hC00004);
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
